// File: rtl/mux_16to1.sv
// 16:1 lane selector: combinational output via a balanced 2:1 tree plus a registered copy with valid.
// Optional MUX_16TO1_SEL_REG_EN: the combinational output selects via a registered copy of sel.
module mux_16to1 #(
    parameter int unsigned DATA_W = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [16*DATA_W-1:0]   in,
    input  logic [3:0]             sel,
    input  logic                   in_valid,
    output logic [DATA_W-1:0]      out,
    output logic [DATA_W-1:0]      out_q,
    output logic                   out_valid
);

    // Four levels of 2:1 muxes: sel[0] picks within lane pairs, sel[3] picks at the root.
    function automatic logic [DATA_W-1:0] tree_sel(
        input logic [16*DATA_W-1:0] v,
        input logic [3:0]           s
    );
        logic [DATA_W-1:0] n1 [8];
        logic [DATA_W-1:0] n2 [4];
        logic [DATA_W-1:0] n3 [2];
        for (int unsigned i = 0; i < 8; i++) begin
            n1[i] = s[0] ? v[(2*i+1)*DATA_W +: DATA_W] : v[(2*i)*DATA_W +: DATA_W];
        end
        for (int unsigned i = 0; i < 4; i++) begin
            n2[i] = s[1] ? n1[2*i+1] : n1[2*i];
        end
        for (int unsigned i = 0; i < 2; i++) begin
            n3[i] = s[2] ? n2[2*i+1] : n2[2*i];
        end
        return s[3] ? n3[1] : n3[0];
    endfunction

    logic [3:0]        tree_s;
    logic [DATA_W-1:0] cap_lane;
    logic [DATA_W-1:0] out_q_q;
    logic [DATA_W-1:0] out_q_d;
    logic              out_valid_q;
    logic              out_valid_d;

`ifdef MUX_16TO1_SEL_REG_EN
    logic [3:0] sel_q;
    logic [3:0] sel_d;

    always_comb begin
        sel_d = sel_q;
        if (in_valid) begin
            sel_d = sel;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q <= '0;
        end else begin
            sel_q <= sel_d;
        end
    end

    assign tree_s = sel_q;
`else
    assign tree_s = sel;
`endif

    assign out      = tree_sel(in, tree_s);
    // Capture always uses the incoming sel, even when out is driven from the registered select.
    assign cap_lane = tree_sel(in, sel);

    always_comb begin
        out_q_d     = out_q_q;
        out_valid_d = in_valid;
        if (in_valid) begin
            out_q_d = cap_lane;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_q_q     <= out_q_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_q     = out_q_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mux_16to1.sv
// Randomized scoreboard bench for mux_16to1, exercising DATA_W=1 and DATA_W=8 instances side by side.
module tb_mux_16to1;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic [3:0]   sel;
    logic [15:0]  in1;
    logic [127:0] in8;
    logic [0:0]   out1, out_q1;
    logic [7:0]   out8, out_q8;
    logic         out_valid1, out_valid8;

    int unsigned checks = 0;
    int unsigned errors = 0;

    typedef struct packed {
        logic [0:0] e1;
        logic [7:0] e8;
    } exp_t;

    exp_t       sb[$];
    exp_t       hold;
    logic [3:0] cap_sel;
    bit         mon_en = 1'b0;

    always #5 clk = ~clk;

    mux_16to1 #(.DATA_W(1)) d1 (
        .clk(clk), .rst_n(rst_n), .in(in1), .sel(sel), .in_valid(in_valid),
        .out(out1), .out_q(out_q1), .out_valid(out_valid1)
    );

    mux_16to1 #(.DATA_W(8)) d8 (
        .clk(clk), .rst_n(rst_n), .in(in8), .sel(sel), .in_valid(in_valid),
        .out(out8), .out_q(out_q8), .out_valid(out_valid8)
    );

    function automatic logic [0:0] ref1(input logic [15:0] v, input int unsigned k);
        return v[k];
    endfunction

    function automatic logic [7:0] ref8(input logic [127:0] v, input int unsigned k);
        return v[k*8 +: 8];
    endfunction

    // Select the combinational output should currently be using.
    function automatic logic [3:0] comb_sel();
`ifdef MUX_16TO1_SEL_REG_EN
        return cap_sel;
`else
        return sel;
`endif
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_comb(input string name);
        chk({name, "_out1"}, {7'b0, out1}, {7'b0, ref1(in1, comb_sel())});
        chk({name, "_out8"}, out8, ref8(in8, comb_sel()));
    endtask

    // Drive one cycle's inputs, check the combinational path, then let the edge capture them.
    task automatic cycle(input logic v, input logic [15:0] a1, input logic [127:0] a8, input logic [3:0] s);
        in_valid = v;
        in1      = a1;
        in8      = a8;
        sel      = s;
        #1;
        chk_comb("rand_comb");
        @(posedge clk);
        if (v && rst_n) begin
            sb.push_back('{e1: ref1(a1, s), e8: ref8(a8, s)});
            cap_sel = s;
        end
        #2;
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            chk("valid1", {7'b0, out_valid1}, {7'b0, sb.size() != 0});
            chk("valid8", {7'b0, out_valid8}, {7'b0, sb.size() != 0});
            if (sb.size() != 0) begin
                hold = sb.pop_front();
            end
            chk("out_q1", {7'b0, out_q1}, {7'b0, hold.e1});
            chk("out_q8", out_q8, hold.e8);
        end
    end

    initial begin
        #1000000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0]  w;
        logic [127:0] lanes;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        sel      = '0;
        in1      = '0;
        in8      = '0;
        hold     = '0;
        cap_sel  = '0;
        #1;
        chk("rst_out_q1", {7'b0, out_q1}, 8'h00);
        chk("rst_valid1", {7'b0, out_valid1}, 8'h00);
        chk("rst_out_q8", out_q8, 8'h00);
        chk("rst_valid8", {7'b0, out_valid8}, 8'h00);
        mon_en = 1'b1;

        // Combinational checks while reset is held: out must ignore reset.
        in1 = 16'h3f0a;
        foreach (w[i]) begin end
        for (int i = 0; i < 4; i++) begin
            logic [3:0] steps [4];
            steps = '{4'd0, 4'd1, 4'd6, 4'd12};
            sel = steps[i];
            #0;
            #1;
            chk_comb("step_3f0a");
            #4;
        end

        in1 = 16'h8001;
        for (int s = 0; s < 16; s++) begin
            sel = 4'(s);
            #1;
            chk_comb("ends_8001");
        end

        for (int k = 0; k < 16; k++) begin
            w   = '0;
            w[k] = 1'b1;
            in1 = w;
            for (int s = 0; s < 16; s++) begin
                sel = 4'(s);
                #1;
                chk_comb("walk1");
            end
        end

        for (int k = 0; k < 16; k++) lanes[k*8 +: 8] = 8'(k);
        in8 = lanes;
        sel = 4'd9;
        #1;
        chk_comb("lanes_sel9");
        chk("lanes_sel9_const", out8, 8'h09);

        // Release reset between edges, then the directed registered sequence.
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        cycle(1'b1, 16'h3f0a, lanes, 4'd12);
        cycle(1'b0, 16'h0000, lanes, 4'd0);
        cycle(1'b1, 16'h0200, lanes, 4'd9);
        chk("sel9_lane8", out8, ref8(lanes, comb_sel()));

        for (int n = 0; n < 200; n++) begin
            cycle(1'($urandom_range(0, 2) != 0), 16'($urandom()), rand128(), 4'($urandom_range(0, 15)));
        end

        // Mid-operation reset right after a valid capture discards the captured data.
        cycle(1'b1, 16'hffff, {16{8'hA5}}, 4'd3);
        #(-2 + 2);
        rst_n = 1'b0;
        sb.delete();
        hold    = '0;
        cap_sel = '0;
        #1;
        chk("midrst_out_q1", {7'b0, out_q1}, 8'h00);
        chk("midrst_valid1", {7'b0, out_valid1}, 8'h00);
        chk("midrst_out_q8", out_q8, 8'h00);
        chk("midrst_valid8", {7'b0, out_valid8}, 8'h00);
        in1 = 16'h0010;
        sel = 4'd4;
        #1;
        chk_comb("midrst_comb");
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        for (int n = 0; n < 100; n++) begin
            cycle(1'($urandom_range(0, 1)), 16'($urandom()), rand128(), 4'($urandom_range(0, 15)));
        end
        cycle(1'b0, 16'h0000, '0, 4'd0);
        cycle(1'b0, 16'h0000, '0, 4'd0);
        @(negedge clk);
        #1;
        mon_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
